tcp_rx_app_sink: RTL
====================

Name: tcp_rx_app_sink

Overview:
- Application-side consumer of the TCP stack's receive interface. It is the responder to the stack's notification / read-request / rx-data protocol.
- Accepts notifications, issues one read-package request per notification, consumes the returned metadata and payload, and keeps windowed throughput counters.
- Sits beside network_stack and drives its s_axis_read_package. It sinks m_axis_notifications, m_axis_rx_metadata and m_axis_rx_data.

Parameters:
- DATA_WIDTH, 512, rx payload width in bits.
- WINDOW_CYCLES, 750000000, measurement window length in aclk cycles.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_notif_valid  in  1  notification valid
- s_notif_ready  out  1  notification ready
- s_notif_data  in  88  [15:0] sessionID, [31:16] length, [63:32] ip, [79:64] port, [80] closed
- m_rdpkg_valid  out  1  read-package request valid
- m_rdpkg_ready  in  1  read-package request ready
- m_rdpkg_data  out  32  [15:0] sessionID, [31:16] length
- s_rxmeta_valid  in  1  rx metadata valid
- s_rxmeta_ready  out  1  rx metadata ready
- s_rxmeta_data  in  16  sessionID
- s_rxdata_valid  in  1  payload beat valid
- s_rxdata_ready  out  1  payload beat ready
- s_rxdata_data  in  DATA_WIDTH  payload
- s_rxdata_keep  in  DATA_WIDTH/8  byte enables
- s_rxdata_last  in  1  last beat of package
- rx_byte_cnt  out  64  bytes consumed in current window
- rx_pkt_cnt  out  32  packages completed in current window
- rx_cycles  out  64  cycles since first notification in window
- close_cnt  out  32  close notifications seen (never windowed)
- sid_err  out  1  sticky: metadata sessionID differs from request

Behaviour:
- Reset: FSM=IDLE; every output valid/ready=0; all counters=0; sid_err=0; rcvd_first=0.
- FSM states: IDLE, REQ, META, DATA.
- IDLE: s_notif_ready=1. On handshake, latch sid and len.
  - If closed=1: close_cnt+1, stay IDLE.
  - Else if len==0: stay IDLE, no request.
  - Else go to REQ.
- REQ: m_rdpkg_valid=1 with {len,sid}. The request is registered and held stable until m_rdpkg_ready. On handshake go to META. Minimum latency notification→request valid = 1 cycle.
- META: s_rxmeta_ready=1. On handshake, compare to latched sid; on mismatch set sid_err (sticky until reset). Go to DATA.
- DATA: s_rxdata_ready=1. Each handshake adds popcount(keep) to the beat byte sum. On beat with last=1: rx_pkt_cnt+1, go to IDLE. Payload is discarded.
- Ready rule: only the ready for the current state's channel is high; all others are 0. Readies are never gated on valid.
- Window logic:
  - rcvd_first is set on the first notification handshake while clear.
  - rx_cycles increments while rcvd_first=1.
  - When rx_cycles==WINDOW_CYCLES: rx_cycles, rx_byte_cnt and rx_pkt_cnt clear to 0, and rcvd_first clears.
- Window boundary priority: the clear wins over a simultaneous increment; that beat's bytes and that completion are dropped. A notification arriving in the same cycle re-arms rcvd_first on the next cycle.
- Counters wrap modulo 2^width without saturation.
- Reset mid-package: FSM returns to IDLE; the stack's remaining beats are not drained (the stack is reset with the block).

Optional Feature:
- Macro: RX_LEN_CHECK_EN.
- Defined:
  - Adds output len_err (1 bit, sticky, reset 0).
  - A per-package byte accumulator (16 bits) is compared with the latched len on the last beat. len_err is set on mismatch.
  - len_err is also set if the accumulator would exceed len before last.
- Undefined: no accumulator, no len_err port, no comparator logic.

Decomposition:
- Package tcp_app_pkg holds:
  - notification field offsets/widths (SID_W=16, LEN_W=16, closed bit index 80), NOTIF_W=88, RDPKG_W=32;
  - the FSM state enum typedef.
- Sub-module keep_popcount (parameter KEEP_W; combinational adder tree, optional output register).
  - DATA_WIDTH=512 uses the registered variant, adding 1 cycle of lag to byte counting only (not to ready).

Test Plan:
- Notification sid=5, len=128 → request {128,5} appears; meta 5; 2 full-keep beats with last on beat 2 → rx_byte_cnt=128, rx_pkt_cnt=1, sid_err=0, FSM back in IDLE.
- Read-request backpressure: m_rdpkg_ready held 0 for 10 cycles → m_rdpkg_valid/data stable; no new notification is accepted (s_notif_ready=0).
- Close notification (closed=1) then len=0 notification → close_cnt=1, no request issued, rx_pkt_cnt=0.
- Metadata sid=7 after request sid=5 → sid_err=1 and stays 1 through later correct packages.
- WINDOW_CYCLES=100: first notification at cycle 10 → rx_cycles reaches 100, then all window counters read 0 the next cycle; a beat in the clear cycle is not counted.
- RX_LEN_CHECK_EN: len=100, beats deliver 64+40 bytes → len_err=1; repeat with 64+36 bytes → len_err stays 0 on a fresh reset.

Source files
------------

// File: rtl/tcp_app_pkg.sv
// Shared field layout and FSM state type for the TCP rx application sink.
package tcp_app_pkg;
  localparam int SID_W      = 16;
  localparam int LEN_W      = 16;
  localparam int SID_LSB    = 0;
  localparam int LEN_LSB    = 16;
  localparam int CLOSED_BIT = 80;
  localparam int NOTIF_W    = 88;
  localparam int RDPKG_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_META,
    ST_DATA
  } app_st_e;
endpackage

// File: rtl/tcp_rx_app_sink_keep_popcount.sv
// Byte-enable popcount with an optional output register; a side tag rides
// along with the same latency so the consumer can pair count and context.
module keep_popcount #(
  parameter int KEEP_W  = 64,
  parameter int TAG_W   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_vld,
  input  logic [KEEP_W-1:0]          i_keep,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_vld,
  output logic [$clog2(KEEP_W+1)-1:0] o_cnt,
  output logic [TAG_W-1:0]           o_tag
);
  localparam int CNT_W = $clog2(KEEP_W+1);

  logic [CNT_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KEEP_W; i++) w_sum = w_sum + CNT_W'(i_keep[i]);
  end

  generate
    if (REG_OUT) begin : g_reg
      logic             r_vld;
      logic [CNT_W-1:0] r_cnt;
      logic [TAG_W-1:0] r_tag;
      always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
          r_vld <= 1'b0;
          r_cnt <= '0;
          r_tag <= '0;
        end else begin
          r_vld <= i_vld;
          r_cnt <= w_sum;
          r_tag <= i_tag;
        end
      end
      assign o_vld = r_vld;
      assign o_cnt = r_cnt;
      assign o_tag = r_tag;
    end else begin : g_comb
      assign o_vld = i_vld;
      assign o_cnt = w_sum;
      assign o_tag = i_tag;
    end
  endgenerate
endmodule

// File: rtl/tcp_rx_app_sink.sv
// Application-side responder to the TCP stack rx path with windowed counters.
// Optional RX_LEN_CHECK_EN adds a sticky len_err per-package length check.
module tcp_rx_app_sink
  import tcp_app_pkg::*;
#(
  parameter int          DATA_WIDTH    = 512,
  parameter logic [63:0] WINDOW_CYCLES = 64'd750000000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_notif_valid,
  output logic                    s_notif_ready,
  input  logic [NOTIF_W-1:0]      s_notif_data,
  output logic                    m_rdpkg_valid,
  input  logic                    m_rdpkg_ready,
  output logic [RDPKG_W-1:0]      m_rdpkg_data,
  input  logic                    s_rxmeta_valid,
  output logic                    s_rxmeta_ready,
  input  logic [SID_W-1:0]        s_rxmeta_data,
  input  logic                    s_rxdata_valid,
  output logic                    s_rxdata_ready,
  input  logic [DATA_WIDTH-1:0]   s_rxdata_data,
  input  logic [DATA_WIDTH/8-1:0] s_rxdata_keep,
  input  logic                    s_rxdata_last,
  output logic [63:0]             rx_byte_cnt,
  output logic [31:0]             rx_pkt_cnt,
  output logic [63:0]             rx_cycles,
  output logic [31:0]             close_cnt,
`ifdef RX_LEN_CHECK_EN
  output logic                    len_err,
`endif
  output logic                    sid_err
);
  localparam int KEEP_W = DATA_WIDTH/8;
  localparam int PC_W   = $clog2(KEEP_W+1);
  localparam bit PC_REG = (DATA_WIDTH >= 512);

  app_st_e          r_st;
  logic [SID_W-1:0] r_sid;
  logic [LEN_W-1:0] r_len;
  logic             r_rcvd_first;

  logic             w_notif_hs, w_rdpkg_hs, w_meta_hs, w_beat_hs, w_clr;
  logic [SID_W-1:0] w_nsid;
  logic [LEN_W-1:0] w_nlen;
  logic             w_pc_vld;
  logic [PC_W-1:0]  w_pc_cnt;
  logic [1:0]       w_pc_tag;

  assign w_notif_hs = s_notif_valid  & s_notif_ready;
  assign w_rdpkg_hs = m_rdpkg_valid  & m_rdpkg_ready;
  assign w_meta_hs  = s_rxmeta_valid & s_rxmeta_ready;
  assign w_beat_hs  = s_rxdata_valid & s_rxdata_ready;
  assign w_clr      = (rx_cycles == WINDOW_CYCLES);
  assign w_nsid     = s_notif_data[SID_LSB +: SID_W];
  assign w_nlen     = s_notif_data[LEN_LSB +: LEN_W];

  // Tag = {beat fell in a window-clear cycle, last beat}
  keep_popcount #(.KEEP_W(KEEP_W), .TAG_W(2), .REG_OUT(PC_REG)) u_pc (
    .i_clk  (aclk),
    .i_rstn (aresetn),
    .i_vld  (w_beat_hs),
    .i_keep (s_rxdata_keep),
    .i_tag  ({w_clr, s_rxdata_last}),
    .o_vld  (w_pc_vld),
    .o_cnt  (w_pc_cnt),
    .o_tag  (w_pc_tag)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_st           <= ST_IDLE;
      s_notif_ready  <= 1'b0;
      m_rdpkg_valid  <= 1'b0;
      m_rdpkg_data   <= '0;
      s_rxmeta_ready <= 1'b0;
      s_rxdata_ready <= 1'b0;
      r_sid          <= '0;
      r_len          <= '0;
      close_cnt      <= '0;
      sid_err        <= 1'b0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          s_notif_ready <= 1'b1;
          if (w_notif_hs) begin
            r_sid <= w_nsid;
            r_len <= w_nlen;
            if (s_notif_data[CLOSED_BIT]) begin
              close_cnt <= close_cnt + 32'd1;
            end else if (w_nlen != '0) begin
              r_st          <= ST_REQ;
              s_notif_ready <= 1'b0;
              m_rdpkg_valid <= 1'b1;
              m_rdpkg_data  <= {w_nlen, w_nsid};
            end
          end
        end
        ST_REQ: if (w_rdpkg_hs) begin
          m_rdpkg_valid  <= 1'b0;
          s_rxmeta_ready <= 1'b1;
          r_st           <= ST_META;
        end
        ST_META: if (w_meta_hs) begin
          if (s_rxmeta_data != r_sid) sid_err <= 1'b1;
          s_rxmeta_ready <= 1'b0;
          s_rxdata_ready <= 1'b1;
          r_st           <= ST_DATA;
        end
        ST_DATA: if (w_beat_hs && s_rxdata_last) begin
          s_rxdata_ready <= 1'b0;
          s_notif_ready  <= 1'b1;
          r_st           <= ST_IDLE;
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  // Window clear beats any same-cycle increment; a same-cycle notification re-arms.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rcvd_first <= 1'b0;
      rx_cycles    <= '0;
      rx_byte_cnt  <= '0;
      rx_pkt_cnt   <= '0;
    end else if (w_clr) begin
      r_rcvd_first <= w_notif_hs;
      rx_cycles    <= '0;
      rx_byte_cnt  <= '0;
      rx_pkt_cnt   <= '0;
    end else begin
      r_rcvd_first <= r_rcvd_first | w_notif_hs;
      if (r_rcvd_first) rx_cycles <= rx_cycles + 64'd1;
      if (w_pc_vld && !w_pc_tag[1]) rx_byte_cnt <= rx_byte_cnt + 64'(w_pc_cnt);
      if (w_beat_hs && s_rxdata_last) rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
    end
  end

`ifdef RX_LEN_CHECK_EN
  logic [LEN_W-1:0] r_acc;
  logic [LEN_W:0]   w_acc_sum;

  assign w_acc_sum = {1'b0, r_acc} + (LEN_W+1)'(w_pc_cnt);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_acc   <= '0;
      len_err <= 1'b0;
    end else if (w_pc_vld) begin
      if (w_pc_tag[0]) begin
        if (w_acc_sum != {1'b0, r_len}) len_err <= 1'b1;
        r_acc <= '0;
      end else begin
        if (w_acc_sum > {1'b0, r_len}) len_err <= 1'b1;
        r_acc <= w_acc_sum[LEN_W-1:0];
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{s_rxdata_data, s_notif_data[NOTIF_W-1:CLOSED_BIT+1],
                      s_notif_data[CLOSED_BIT-1:LEN_LSB+LEN_W]};
`else
  logic w_unused;
  assign w_unused = ^{s_rxdata_data, s_notif_data[NOTIF_W-1:CLOSED_BIT+1],
                      s_notif_data[CLOSED_BIT-1:LEN_LSB+LEN_W], r_len, w_pc_tag[0]};
`endif
endmodule
